test_sequencer_fsm: RTL and testbench

TEST_SEQUENCER_FSM -- requirements
Module: test_sequencer_fsm

---
 rtl/seq_pkg.sv | 88 ++++++++
 rtl/seq_word_decode.sv | 66 ++++++
 rtl/test_sequencer_fsm.sv | 200 ++++++++++++++++++++
 tb/tb_test_sequencer_fsm.sv | 301 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/seq_pkg.sv
// seq_pkg -- shared definitions for the test sequencer.
//   Opcode constants used by the instruction stream, datapath flag bit
//   positions, program-word field offsets (as functions of the field widths),
//   the sequencer state encoding and the default pass/fail signatures.
//   Optional feature macro used by the sequencer: SEQ_ERR_COUNT_EN.
package seq_pkg;

  // Opcodes understood by the downstream datapath.
  localparam logic [7:0] OP_NOP  = 8'h00;
  localparam logic [7:0] OP_AND  = 8'h01;
  localparam logic [7:0] OP_OR   = 8'h02;
  localparam logic [7:0] OP_XOR  = 8'h03;
  localparam logic [7:0] OP_ADD  = 8'h05;
  localparam logic [7:0] OP_ADDU = 8'h06;
  localparam logic [7:0] OP_SUB  = 8'h09;
  localparam logic [7:0] OP_CMP  = 8'h0B;
  localparam logic [7:0] OP_MOV  = 8'h0D;
  localparam logic [7:0] OP_SUBI = 8'h90;
  localparam logic [7:0] OP_CMPI = 8'hB0;
  localparam logic [7:0] OP_MOVI = 8'hD0;

  // Datapath flag bit positions (C, L, F=overflow, Z, N).
  localparam int FLAG_C = 0;
  localparam int FLAG_L = 1;
  localparam int FLAG_F = 2;
  localparam int FLAG_Z = 3;
  localparam int FLAG_N = 4;

  // Signature written to the top register when a program finishes.
  localparam logic [15:0] PASS_SIG_DEF = 16'h1111;
  localparam logic [15:0] FAIL_SIG_DEF = 16'hDEAD;

  // Sequencer states; also visible on the Dbg_State output.
  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ISSUE = 3'd1,
    S_CHECK = 3'd2,
    S_SIG   = 3'd3,
    S_DONE  = 3'd4
  } seq_state_t;

  // Program-word layout, LSB first:
  //   last, chk, wr, imm_sel, mask, exp, rsrc, rdest, opcode, imm
  function automatic int off_last();
    return 0;
  endfunction

  function automatic int off_chk();
    return 1;
  endfunction

  function automatic int off_wr();
    return 2;
  endfunction

  function automatic int off_imm_sel();
    return 3;
  endfunction

  function automatic int off_mask();
    return 4;
  endfunction

  function automatic int off_exp(input int fw);
    return 4 + fw;
  endfunction

  function automatic int off_rsrc(input int fw);
    return 4 + 2 * fw;
  endfunction

  function automatic int off_rdest(input int fw, input int sw);
    return 4 + 2 * fw + sw;
  endfunction

  function automatic int off_opcode(input int fw, input int sw);
    return 4 + 2 * fw + 2 * sw;
  endfunction

  function automatic int off_imm(input int fw, input int sw, input int ow);
    return 4 + 2 * fw + 2 * sw + ow;
  endfunction

  function automatic int prog_width(input int fw, input int sw, input int ow, input int bw);
    return 4 + 2 * fw + 2 * sw + ow + bw;
  endfunction

endpackage

// File: rtl/seq_word_decode.sv
// seq_word_decode -- splits one program-table word into its fields and
// builds the one-hot register-file write enable.
//   i_word     : program word (PROG_WIDTH bits)
//   o_last     : last-instruction marker
//   o_chk      : flag check requested after this instruction
//   o_imm_sel  : immediate operand select
//   o_mask     : flag compare mask
//   o_exp      : expected flag values
//   o_rsrc     : source register select
//   o_rdest    : destination register select
//   o_opcode   : datapath opcode
//   o_imm      : immediate value
//   o_wr_en    : one-hot write enable for rdest, zero when wr=0
module seq_word_decode
  import seq_pkg::*;
#(
  parameter int BIT_WIDTH    = 16,
  parameter int OPCODE_WIDTH = 8,
  parameter int FLAG_WIDTH   = 5,
  parameter int SEL_WIDTH    = 4,
  localparam int NUM_REGS    = 2 ** SEL_WIDTH,
  localparam int PROG_WIDTH  = prog_width(FLAG_WIDTH, SEL_WIDTH, OPCODE_WIDTH, BIT_WIDTH)
) (
  input  logic [PROG_WIDTH-1:0]   i_word,
  output logic                    o_last,
  output logic                    o_chk,
  output logic                    o_imm_sel,
  output logic [FLAG_WIDTH-1:0]   o_mask,
  output logic [FLAG_WIDTH-1:0]   o_exp,
  output logic [SEL_WIDTH-1:0]    o_rsrc,
  output logic [SEL_WIDTH-1:0]    o_rdest,
  output logic [OPCODE_WIDTH-1:0] o_opcode,
  output logic [BIT_WIDTH-1:0]    o_imm,
  output logic [NUM_REGS-1:0]     o_wr_en
);

  localparam int OFF_LAST    = off_last();
  localparam int OFF_CHK     = off_chk();
  localparam int OFF_WR      = off_wr();
  localparam int OFF_IMM_SEL = off_imm_sel();
  localparam int OFF_MASK    = off_mask();
  localparam int OFF_EXP     = off_exp(FLAG_WIDTH);
  localparam int OFF_RSRC    = off_rsrc(FLAG_WIDTH);
  localparam int OFF_RDEST   = off_rdest(FLAG_WIDTH, SEL_WIDTH);
  localparam int OFF_OPCODE  = off_opcode(FLAG_WIDTH, SEL_WIDTH);
  localparam int OFF_IMM     = off_imm(FLAG_WIDTH, SEL_WIDTH, OPCODE_WIDTH);

  logic w_wr;

  assign o_last    = i_word[OFF_LAST];
  assign o_chk     = i_word[OFF_CHK];
  assign w_wr      = i_word[OFF_WR];
  assign o_imm_sel = i_word[OFF_IMM_SEL];
  assign o_mask    = i_word[OFF_MASK +: FLAG_WIDTH];
  assign o_exp     = i_word[OFF_EXP +: FLAG_WIDTH];
  assign o_rsrc    = i_word[OFF_RSRC +: SEL_WIDTH];
  assign o_rdest   = i_word[OFF_RDEST +: SEL_WIDTH];
  assign o_opcode  = i_word[OFF_OPCODE +: OPCODE_WIDTH];
  assign o_imm     = i_word[OFF_IMM +: BIT_WIDTH];

  always_comb begin
    o_wr_en = '0;
    if (w_wr) o_wr_en[o_rdest] = 1'b1;
  end

endmodule

// File: rtl/test_sequencer_fsm.sv
// test_sequencer_fsm -- walks a self-test program table, issues one datapath
// instruction per cycle, checks datapath flags after flagged instructions
// and finally writes a pass/fail signature into the top register.
//   Clk, Rst      : clock; asynchronous active-low reset
//   Start         : run request (ignored while Busy)
//   Prog_Word     : program word at Prog_Addr (combinational table read)
//   Flags         : datapath flags, valid the cycle after an issue
//   Prog_Addr     : program counter
//   Opcode, Rsrc_mux_sel, Rdest_mux_sel, Imm_mux_sel, Imm_val, Reg_File_En :
//                   datapath control for the current cycle
//   Busy, Done, Pass, Err_Count : run status
//   Dbg_State     : current FSM state
// Handshake: Start is sampled on a rising Clk edge only in S_IDLE or S_DONE;
// Done stays high from the end of a run until the next accepted Start.
// Macro SEQ_ERR_COUNT_EN: when defined, every flag mismatch bumps a saturating
// error count and the program runs to the end; otherwise the first mismatch
// aborts straight to the FAIL signature with Err_Count=1.
module test_sequencer_fsm
  import seq_pkg::*;
#(
  parameter int BIT_WIDTH    = 16,
  parameter int OPCODE_WIDTH = 8,
  parameter int FLAG_WIDTH   = 5,
  parameter int SEL_WIDTH    = 4,
  parameter int PC_WIDTH     = 6,
  parameter int ERR_WIDTH    = 8,
  parameter logic [BIT_WIDTH-1:0] PASS_SIG = PASS_SIG_DEF,
  parameter logic [BIT_WIDTH-1:0] FAIL_SIG = FAIL_SIG_DEF,
  localparam int NUM_REGS    = 2 ** SEL_WIDTH,
  localparam int PROG_WIDTH  = prog_width(FLAG_WIDTH, SEL_WIDTH, OPCODE_WIDTH, BIT_WIDTH)
) (
  input  logic                    Clk,
  input  logic                    Rst,
  input  logic                    Start,
  input  logic [PROG_WIDTH-1:0]   Prog_Word,
  input  logic [FLAG_WIDTH-1:0]   Flags,
  output logic [PC_WIDTH-1:0]     Prog_Addr,
  output logic [OPCODE_WIDTH-1:0] Opcode,
  output logic [SEL_WIDTH-1:0]    Rsrc_mux_sel,
  output logic [SEL_WIDTH-1:0]    Rdest_mux_sel,
  output logic                    Imm_mux_sel,
  output logic [BIT_WIDTH-1:0]    Imm_val,
  output logic [NUM_REGS-1:0]     Reg_File_En,
  output logic                    Busy,
  output logic                    Done,
  output logic                    Pass,
  output logic [ERR_WIDTH-1:0]    Err_Count,
  output logic [2:0]              Dbg_State
);

  seq_state_t             r_state;
  logic [PC_WIDTH-1:0]    r_pc;
  logic [ERR_WIDTH-1:0]   r_err_count;
  logic                   r_pass;
  logic                   r_done;
  logic                   r_busy;

  logic                    w_last;
  logic                    w_chk;
  logic                    w_imm_sel;
  logic [FLAG_WIDTH-1:0]   w_mask;
  logic [FLAG_WIDTH-1:0]   w_exp;
  logic [SEL_WIDTH-1:0]    w_rsrc;
  logic [SEL_WIDTH-1:0]    w_rdest;
  logic [OPCODE_WIDTH-1:0] w_opcode;
  logic [BIT_WIDTH-1:0]    w_imm;
  logic [NUM_REGS-1:0]     w_wr_en;
  logic                    w_pc_end;
  logic                    w_mismatch;
  logic                    w_stop;

  seq_word_decode #(
    .BIT_WIDTH    (BIT_WIDTH),
    .OPCODE_WIDTH (OPCODE_WIDTH),
    .FLAG_WIDTH   (FLAG_WIDTH),
    .SEL_WIDTH    (SEL_WIDTH)
  ) u_decode (
    .i_word    (Prog_Word),
    .o_last    (w_last),
    .o_chk     (w_chk),
    .o_imm_sel (w_imm_sel),
    .o_mask    (w_mask),
    .o_exp     (w_exp),
    .o_rsrc    (w_rsrc),
    .o_rdest   (w_rdest),
    .o_opcode  (w_opcode),
    .o_imm     (w_imm),
    .o_wr_en   (w_wr_en)
  );

  // The top address is an implicit last instruction so the PC never wraps.
  assign w_pc_end   = &r_pc;
  assign w_stop     = w_last | w_pc_end;
  assign w_mismatch = |((Flags ^ w_exp) & w_mask);

`ifdef SEQ_ERR_COUNT_EN
  logic [ERR_WIDTH-1:0] w_err_inc;
  assign w_err_inc = (&r_err_count) ? r_err_count : r_err_count + ERR_WIDTH'(1);
`endif

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      r_state     <= S_IDLE;
      r_pc        <= '0;
      r_err_count <= '0;
      r_pass      <= 1'b0;
      r_done      <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          if (Start) begin
            r_state     <= S_ISSUE;
            r_pc        <= '0;
            r_err_count <= '0;
            r_pass      <= 1'b0;
            r_done      <= 1'b0;
            r_busy      <= 1'b1;
          end
        end
        S_ISSUE: begin
          if (w_chk)       r_state <= S_CHECK;
          else if (w_stop) r_state <= S_SIG;
          else             r_pc    <= r_pc + PC_WIDTH'(1);
        end
        S_CHECK: begin
`ifdef SEQ_ERR_COUNT_EN
          if (w_mismatch) r_err_count <= w_err_inc;
          if (w_stop) begin
            r_state <= S_SIG;
          end else begin
            r_state <= S_ISSUE;
            r_pc    <= r_pc + PC_WIDTH'(1);
          end
`else
          // First mismatch aborts the rest of the program.
          if (w_mismatch) begin
            r_err_count <= ERR_WIDTH'(1);
            r_state     <= S_SIG;
          end else if (w_stop) begin
            r_state <= S_SIG;
          end else begin
            r_state <= S_ISSUE;
            r_pc    <= r_pc + PC_WIDTH'(1);
          end
`endif
        end
        S_SIG: begin
          r_state <= S_DONE;
          r_busy  <= 1'b0;
          r_done  <= 1'b1;
          r_pass  <= (r_err_count == '0);
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
        end
      endcase
    end
  end

  // Datapath controls follow the state directly so an asynchronous reset
  // removes any in-flight write enable in the same cycle.
  always_comb begin
    Opcode        = '0;
    Rsrc_mux_sel  = '0;
    Rdest_mux_sel = '0;
    Imm_mux_sel   = 1'b0;
    Imm_val       = '0;
    Reg_File_En   = '0;
    case (r_state)
      S_ISSUE: begin
        Opcode        = w_opcode;
        Rsrc_mux_sel  = w_rsrc;
        Rdest_mux_sel = w_rdest;
        Imm_mux_sel   = w_imm_sel;
        Imm_val       = w_imm;
        Reg_File_En   = w_wr_en;
      end
      S_SIG: begin
        Opcode                  = OPCODE_WIDTH'(OP_MOVI);
        Rsrc_mux_sel            = '1;
        Rdest_mux_sel           = '1;
        Imm_mux_sel             = 1'b1;
        Imm_val                 = (r_err_count == '0) ? PASS_SIG : FAIL_SIG;
        Reg_File_En[NUM_REGS-1] = 1'b1;
      end
      default: ;
    endcase
  end

  assign Prog_Addr = r_pc;
  assign Busy      = r_busy;
  assign Done      = r_done;
  assign Pass      = r_pass;
  assign Err_Count = r_err_count;
  assign Dbg_State = r_state;

endmodule

// File: tb/tb_test_sequencer_fsm.sv
// tb_test_sequencer_fsm -- scoreboard bench for test_sequencer_fsm.
// Every non-NOP cycle the DUT presents is one issued instruction; the monitor
// pops the expected instruction from exp_q and compares all control fields.
module tb_test_sequencer_fsm;

  logic        Clk = 1'b0;
  logic        Rst = 1'b0;
  logic        Start = 1'b0;
  logic [45:0] Prog_Word;
  logic [4:0]  Flags;
  logic [5:0]  Prog_Addr;
  logic [7:0]  Opcode;
  logic [3:0]  Rsrc_mux_sel, Rdest_mux_sel;
  logic        Imm_mux_sel;
  logic [15:0] Imm_val;
  logic [15:0] Reg_File_En;
  logic        Busy, Done, Pass;
  logic [7:0]  Err_Count;
  logic [2:0]  Dbg_State;

  logic [45:0] prog_mem [64];
  logic [4:0]  flags_tab [64];

  logic [54:0] exp_q[$];
  int total = 0;
  int bad = 0;

  localparam logic [4:0] FV = 5'b00100;
  localparam logic [4:0] FZ = 5'b01000;

  assign Prog_Word = prog_mem[Prog_Addr];
  assign Flags     = flags_tab[Prog_Addr];

  always #5 Clk = ~Clk;

  test_sequencer_fsm dut (
    .Clk(Clk), .Rst(Rst), .Start(Start), .Prog_Word(Prog_Word), .Flags(Flags),
    .Prog_Addr(Prog_Addr), .Opcode(Opcode), .Rsrc_mux_sel(Rsrc_mux_sel),
    .Rdest_mux_sel(Rdest_mux_sel), .Imm_mux_sel(Imm_mux_sel), .Imm_val(Imm_val),
    .Reg_File_En(Reg_File_En), .Busy(Busy), .Done(Done), .Pass(Pass),
    .Err_Count(Err_Count), .Dbg_State(Dbg_State)
  );

  function automatic logic [45:0] mk_word(input logic [15:0] imm, input logic [7:0] op,
                                          input logic [3:0] rd, input logic [3:0] rs,
                                          input logic [4:0] ex, input logic [4:0] mk,
                                          input logic isel, input logic wr,
                                          input logic chk, input logic last);
    return {imm, op, rd, rs, ex, mk, isel, wr, chk, last};
  endfunction

  function automatic logic [54:0] tx(input logic [5:0] a, input logic [7:0] op,
                                     input logic [3:0] rs, input logic [3:0] rd,
                                     input logic isel, input logic [15:0] imm,
                                     input logic [15:0] en);
    return {a, op, rs, rd, isel, imm, en};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%h expected=%h", name, act, exp);
    end
  endtask

  // ---------------- monitor / scoreboard ----------------
  always @(negedge Clk) begin
    logic [54:0] obs;
    logic [54:0] e;
    if (Rst && Opcode != 8'h00) begin
      obs = tx(Prog_Addr, Opcode, Rsrc_mux_sel, Rdest_mux_sel, Imm_mux_sel, Imm_val, Reg_File_En);
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_issue got=%h expected=none", obs);
      end else begin
        e = exp_q.pop_front();
        check("issue", obs, e);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic clear_mem();
    for (int i = 0; i < 64; i++) begin
      prog_mem[i]  = '0;
      flags_tab[i] = '0;
    end
  endtask

  // MOVI R0,7FFF; MOVI R1,1; ADD R2 (chk V=1); CMPI R4,0 (chk Z=1, last)
  task automatic load_prog1(input logic [4:0] f2, input logic [4:0] f3);
    clear_mem();
    prog_mem[0] = mk_word(16'h7FFF, 8'hD0, 4'd0, 4'd0, 5'd0, 5'd0, 1'b1, 1'b1, 1'b0, 1'b0);
    prog_mem[1] = mk_word(16'h0001, 8'hD0, 4'd1, 4'd0, 5'd0, 5'd0, 1'b1, 1'b1, 1'b0, 1'b0);
    prog_mem[2] = mk_word(16'h0000, 8'h05, 4'd2, 4'd1, FV,   FV,   1'b0, 1'b1, 1'b1, 1'b0);
    prog_mem[3] = mk_word(16'h0000, 8'hB0, 4'd4, 4'd4, FZ,   FZ,   1'b1, 1'b0, 1'b1, 1'b1);
    flags_tab[2] = f2;
    flags_tab[3] = f3;
  endtask

  task automatic push_p1(input int n);
    if (n > 0) exp_q.push_back(tx(6'd0, 8'hD0, 4'd0, 4'd0, 1'b1, 16'h7FFF, 16'h0001));
    if (n > 1) exp_q.push_back(tx(6'd1, 8'hD0, 4'd0, 4'd1, 1'b1, 16'h0001, 16'h0002));
    if (n > 2) exp_q.push_back(tx(6'd2, 8'h05, 4'd1, 4'd2, 1'b0, 16'h0000, 16'h0004));
    if (n > 3) exp_q.push_back(tx(6'd3, 8'hB0, 4'd4, 4'd4, 1'b1, 16'h0000, 16'h0000));
  endtask

  task automatic push_sig(input logic [5:0] a, input logic [15:0] sig);
    exp_q.push_back(tx(a, 8'hD0, 4'hF, 4'hF, 1'b1, sig, 16'h8000));
  endtask

  task automatic start_run();
    @(negedge Clk);
    Start = 1'b1;
    @(negedge Clk);
    Start = 1'b0;
  endtask

  task automatic wait_done(input string name, input int budget);
    int n;
    n = 0;
    while (Done !== 1'b1 && n < budget) begin
      @(negedge Clk);
      n++;
    end
    if (Done !== 1'b1) check({name, "_done_timeout"}, {63'd0, Done}, 64'd1);
  endtask

  task automatic check_end(input string name, input logic pass, input logic [7:0] err);
    @(negedge Clk);
    #1;
    check({name, "_done"}, {63'd0, Done}, 64'd1);
    check({name, "_busy"}, {63'd0, Busy}, 64'd0);
    check({name, "_pass"}, {63'd0, Pass}, {63'd0, pass});
    check({name, "_err"}, {56'd0, Err_Count}, {56'd0, err});
    check({name, "_queue_left"}, exp_q.size(), 64'd0);
    exp_q.delete();
  endtask

`ifdef SEQ_ERR_COUNT_EN
  // Deeper program table instance for error-count saturation.
  logic        start2 = 1'b0;
  logic [45:0] word2;
  logic [8:0]  addr2;
  logic [7:0]  op2;
  logic [3:0]  rs2, rd2;
  logic        isel2, busy2, done2, pass2;
  logic [15:0] imm2, en2;
  logic [7:0]  err2;
  logic [2:0]  st2;
  logic [45:0] mem2 [512];

  assign word2 = mem2[addr2];

  test_sequencer_fsm #(.PC_WIDTH(9)) dut2 (
    .Clk(Clk), .Rst(Rst), .Start(start2), .Prog_Word(word2), .Flags(5'd0),
    .Prog_Addr(addr2), .Opcode(op2), .Rsrc_mux_sel(rs2), .Rdest_mux_sel(rd2),
    .Imm_mux_sel(isel2), .Imm_val(imm2), .Reg_File_En(en2), .Busy(busy2),
    .Done(done2), .Pass(pass2), .Err_Count(err2), .Dbg_State(st2)
  );
`endif

  // ---------------- main sequence ----------------
  initial begin
    int n;
    clear_mem();
    // Reset state
    #1;
    check("rst_addr", {58'd0, Prog_Addr}, 64'd0);
    check("rst_opcode", {56'd0, Opcode}, 64'd0);
    check("rst_en", {48'd0, Reg_File_En}, 64'd0);
    check("rst_imm", {48'd0, Imm_val}, 64'd0);
    check("rst_flags", {60'd0, Busy, Done, Pass, Imm_mux_sel}, 64'd0);
    check("rst_err", {56'd0, Err_Count}, 64'd0);
    repeat (2) @(negedge Clk);
    Rst = 1'b1;
    repeat (3) @(negedge Clk);
    check("idle_hold_busy", {63'd0, Busy}, 64'd0);

    // 1: passing program
    load_prog1(FV, FZ);
    push_p1(4);
    push_sig(6'd3, 16'h1111);
    start_run();
    wait_done("pass_prog", 40);
    check_end("pass_prog", 1'b1, 8'd0);

    // 2: Z forced low at the final check
    load_prog1(FV, 5'd0);
    push_p1(4);
    push_sig(6'd3, 16'hDEAD);
    start_run();
    wait_done("z_fail", 40);
    check_end("z_fail", 1'b0, 8'd1);

    // 3: V missing at the ADD check
    load_prog1(5'd0, FZ);
`ifdef SEQ_ERR_COUNT_EN
    push_p1(4);
    push_sig(6'd3, 16'hDEAD);
`else
    push_p1(3);
    push_sig(6'd2, 16'hDEAD);
`endif
    start_run();
    wait_done("v_fail", 40);
    check_end("v_fail", 1'b0, 8'd1);

    // 4: 64 plain words, end of table acts as last
    clear_mem();
    for (int i = 0; i < 64; i++) begin
      logic [5:0] a;
      a = 6'(i);
      prog_mem[i] = mk_word({10'd0, a}, 8'hD0, a[3:0], 4'd0, 5'd0, 5'd0, 1'b1, 1'b1, 1'b0, 1'b0);
      exp_q.push_back(tx(a, 8'hD0, 4'd0, a[3:0], 1'b1, {10'd0, a}, 16'h0001 << a[3:0]));
    end
    push_sig(6'd63, 16'h1111);
    start_run();
    wait_done("full_table", 120);
    check_end("full_table", 1'b1, 8'd0);

    // 5: asynchronous reset while checking
    load_prog1(FV, FZ);
    push_p1(3);
    start_run();
    n = 0;
    while (Dbg_State !== 3'd2 && n < 20) begin
      @(negedge Clk);
      n++;
    end
    check("reach_check", {61'd0, Dbg_State}, 64'd2);
    Rst = 1'b0;
    #1;
    check("arst_opcode", {56'd0, Opcode}, 64'd0);
    check("arst_en", {48'd0, Reg_File_En}, 64'd0);
    check("arst_busy_done", {62'd0, Busy, Done}, 64'd0);
    check("arst_addr", {58'd0, Prog_Addr}, 64'd0);
    check("arst_queue", exp_q.size(), 64'd0);
    exp_q.delete();
    @(negedge Clk);
    Rst = 1'b1;
    push_p1(4);
    push_sig(6'd3, 16'h1111);
    start_run();
    wait_done("after_rst", 40);
    check_end("after_rst", 1'b1, 8'd0);

    // 6: Start while Busy ignored; restart from S_DONE clears status
    load_prog1(FV, 5'd0);
    push_p1(4);
    push_sig(6'd3, 16'hDEAD);
    start_run();
    Start = 1'b1;
    repeat (2) @(negedge Clk);
    Start = 1'b0;
    wait_done("busy_start", 40);
    check_end("busy_start", 1'b0, 8'd1);
    flags_tab[3] = FZ;
    push_p1(4);
    push_sig(6'd3, 16'h1111);
    start_run();
    #1;
    check("restart_err", {56'd0, Err_Count}, 64'd0);
    check("restart_pass_done", {62'd0, Pass, Done}, 64'd0);
    check("restart_busy", {63'd0, Busy}, 64'd1);
    wait_done("restart", 40);
    check_end("restart", 1'b1, 8'd0);

`ifdef SEQ_ERR_COUNT_EN
    // 7: 300 mismatching checks saturate the error count
    for (int i = 0; i < 512; i++) mem2[i] = '0;
    for (int i = 0; i < 300; i++)
      mem2[i] = mk_word(16'd0, 8'hB0, 4'd0, 4'd0, FZ, FZ, 1'b1, 1'b0, 1'b1, (i == 299));
    @(negedge Clk);
    start2 = 1'b1;
    @(negedge Clk);
    start2 = 1'b0;
    n = 0;
    while (done2 !== 1'b1 && n < 800) begin
      @(negedge Clk);
      n++;
    end
    check("sat_done", {63'd0, done2}, 64'd1);
    check("sat_err", {56'd0, err2}, 64'hFF);
    check("sat_pass", {63'd0, pass2}, 64'd0);
    check("sat_addr", {55'd0, addr2}, 64'd299);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog got=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
